// File: rtl/ofm_pkg.sv
// Shared constants and types for the OFM packer: lane geometry, quantisation
// limits and the beat/half-word containers used across the block.
package ofm_pkg;
    localparam int LANES       = 16;
    localparam int ACC_W       = 32;
    localparam int OUT_W       = 8;
    localparam int DATA_WIDTH  = 256;
    localparam int FIFO_SIZE   = 512;
    localparam int HALF_W      = LANES * OUT_W;
    localparam int CREDIT_W    = $clog2(FIFO_SIZE) + 1;
    localparam int SHIFT_W     = 5;
    localparam int WCNT_W      = 16;
    localparam int LEAKY_SHIFT = 3;
    localparam int QMIN        = -128;
    localparam int QMAX        = 127;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] q_t;
    typedef acc_t [LANES-1:0]        beat_t;
    typedef q_t   [LANES-1:0]        half_t;
endpackage

// File: rtl/ofm_packer_if.sv
// Beat input from the PE array plus the FIFO write/read-copy strobes.
// master = PE array / FIFO controller side, slave = the packer.
interface ofm_packer_if;
    import ofm_pkg::*;

    logic [SHIFT_W-1:0]    cfg_shift;
    logic                  cfg_leaky_en;
    logic                  in_valid;
    logic                  in_ready;
    beat_t                 in_data;
    logic                  in_last;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  fifo_rd_en;

    modport master (
        output cfg_shift, cfg_leaky_en, in_valid, in_data, in_last, fifo_rd_en,
        input  in_ready, fifo_wr_en, fifo_data_in
    );

    modport slave (
        input  cfg_shift, cfg_leaky_en, in_valid, in_data, in_last, fifo_rd_en,
        output in_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/ofm_requant_lane.sv
// One lane of requantisation: optional leaky-ReLU, round-half-up right shift,
// and saturation to int8. Purely combinational.
module ofm_requant_lane
    import ofm_pkg::*;
(
    input  acc_t               x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               leaky_en_i,
    output q_t                 q_o
);
    // One extra bit so adding the rounding bias to a max-positive value cannot wrap.
    typedef logic signed [ACC_W:0] wide_t;

    localparam wide_t SAT_HI = wide_t'(QMAX);
    localparam wide_t SAT_LO = wide_t'(QMIN);

    wide_t a_val;
    wide_t bias;
    wide_t sum;
    wide_t r_val;

    always_comb begin
        if (leaky_en_i && (x_i < 0)) begin
            a_val = wide_t'(x_i >>> LEAKY_SHIFT);
        end else begin
            a_val = wide_t'(x_i);
        end

        bias = '0;
        if (shift_i != '0) begin
            bias = wide_t'(1) << (shift_i - SHIFT_W'(1));
        end

        sum   = a_val + bias;
        r_val = sum >>> shift_i;

        if (r_val > SAT_HI) begin
            q_o = q_t'(QMAX);
        end else if (r_val < SAT_LO) begin
            q_o = q_t'(QMIN);
        end else begin
            q_o = q_t'(r_val);
        end
    end
endmodule

// File: rtl/ofm_packer.sv
// Requantises accumulator beats to int8, packs two beats per FIFO word and
// throttles the PE array with a credit counter mirroring FIFO occupancy.
module ofm_packer
    import ofm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ofm_packer_if.slave         bus,
    output logic                fifo_full,
    output logic [CREDIT_W-1:0] credit_used,
    output logic [WCNT_W-1:0]   words_written,
    output logic                underflow_err
);
    half_t                 q_lanes;
    logic                  accept;
    logic                  completing;
    logic                  credit_inc;
    logic                  credit_dec;

    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  phase_q, phase_d;
    logic                  underflow_q, underflow_d;

    logic                  s1_valid_q;
    logic                  s1_second_q;
    logic                  s1_last_q;
    half_t                 s1_lanes_q;
    half_t                 half_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [WCNT_W-1:0]     words_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            ofm_requant_lane u_lane (
                .x_i        (bus.in_data[gi]),
                .shift_i    (bus.cfg_shift),
                .leaky_en_i (bus.cfg_leaky_en),
                .q_o        (q_lanes[gi])
            );
        end
    endgenerate

    assign bus.in_ready = !rst && (credit_q < CREDIT_W'(FIFO_SIZE));
    assign accept       = bus.in_valid && bus.in_ready;
    assign completing   = phase_q || bus.in_last;
    // Credit is reserved when the word-completing beat is accepted, not at write time.
    assign credit_inc   = accept && completing;
    assign credit_dec   = bus.fifo_rd_en && (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        if (credit_inc && !credit_dec) begin
            credit_d = credit_q + CREDIT_W'(1);
        end else if (!credit_inc && credit_dec) begin
            credit_d = credit_q - CREDIT_W'(1);
        end

        phase_d = phase_q;
        if (accept) begin
            phase_d = !completing;
        end

        underflow_d = underflow_q || (bus.fifo_rd_en && (credit_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q    <= '0;
            phase_q     <= 1'b0;
            underflow_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_second_q <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_lanes_q  <= '0;
            half_q      <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            words_q     <= '0;
        end else begin
            credit_q    <= credit_d;
            phase_q     <= phase_d;
            underflow_q <= underflow_d;

            s1_valid_q <= accept;
            if (accept) begin
                s1_second_q <= phase_q;
                s1_last_q   <= bus.in_last;
                s1_lanes_q  <= q_lanes;
            end

            wr_en_q <= 1'b0;
            if (s1_valid_q) begin
                if (s1_second_q) begin
                    data_q  <= {s1_lanes_q, half_q};
                    wr_en_q <= 1'b1;
                end else if (s1_last_q) begin
                    data_q  <= {HALF_W'(0), s1_lanes_q};
                    wr_en_q <= 1'b1;
                end else begin
                    half_q <= s1_lanes_q;
                end
            end

            words_q <= words_q + WCNT_W'(wr_en_q);
        end
    end

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign fifo_full        = (credit_q == CREDIT_W'(FIFO_SIZE));
    assign credit_used      = credit_q;
    assign words_written    = words_q;
    assign underflow_err    = underflow_q;
endmodule
